// File: rtl/rf_pkg.sv
// Shared definitions for the register-file write-back path.
//   REG_MEM_SIZE / ADDR_W / DATA_W : register file geometry
//   wb_entry_t                     : one pending multi-cycle result
//   is_zero_reg                    : r0 test (r0 is hardwired, never written)
package rf_pkg;

  localparam int REG_MEM_SIZE = 32;
  localparam int ADDR_W       = $clog2(REG_MEM_SIZE);
  localparam int DATA_W       = 32;

  typedef struct packed {
    logic              killed;  // superseded by a younger ALU write
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  function automatic logic is_zero_reg(input logic [ADDR_W-1:0] a);
    return (a == '0);
  endfunction

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Result-source bundle feeding the write-back arbiter.
//   a_* : ALU results, no backpressure
//   b_* : multi-cycle unit results, valid/ready handshake
// master = result producers, slave = arbiter.
interface rf_wb_arbiter_if #(
  parameter int ADDR_W = rf_pkg::ADDR_W,
  parameter int DATA_W = rf_pkg::DATA_W
);
  logic              a_valid;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_data;
  logic              b_valid;
  logic              b_ready;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_data;

  modport master (
    output a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    input  b_ready
  );

  modport slave (
    input  a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    output b_ready
  );
endinterface

// File: rtl/rf_wb_arbiter_wb_queue.sv
// wb_queue: circular FIFO of pending multi-cycle results.
//   push/push_ent      : append at tail
//   pop / head         : remove / view oldest entry
//   kill/kill_addr     : mark every entry (incl. one pushed this cycle) with
//                        a matching address as killed
//   cnt                : occupied entries, killed ones included
//   lk_addr/lk_hit/lk_data : NLK youngest-live-match search ports
module wb_queue
  import rf_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int NLK   = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          push,
  input  wb_entry_t                     push_ent,
  input  logic                          pop,
  input  logic                          kill,
  input  logic [ADDR_W-1:0]             kill_addr,
  output wb_entry_t                     head,
  output logic [$clog2(DEPTH):0]        cnt,
  input  logic [NLK-1:0][ADDR_W-1:0]    lk_addr,
  output logic [NLK-1:0]                lk_hit,
  output logic [NLK-1:0][DATA_W-1:0]    lk_data
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_entry_t       mem [DEPTH];
  logic [PW-1:0]   rd_ptr, wr_ptr;

  assign head = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      // Broadcast kill; touching free slots is harmless, they get overwritten.
      for (int i = 0; i < DEPTH; i++)
        if (kill && mem[i].addr == kill_addr) mem[i].killed <= 1'b1;
      if (push) begin
        mem[wr_ptr] <= '{killed: push_ent.killed | (kill && push_ent.addr == kill_addr),
                         addr:   push_ent.addr,
                         data:   push_ent.data};
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Walk occupied slots oldest-first; a later match overrides, so the
  // youngest live entry wins.
  always_comb begin
    lk_hit  = '0;
    lk_data = '0;
    for (int l = 0; l < NLK; l++)
      for (int i = 0; i < DEPTH; i++)
        if (CW'(i) < cnt && !mem[rd_ptr + PW'(i)].killed &&
            mem[rd_ptr + PW'(i)].addr == lk_addr[l]) begin
          lk_hit[l]  = 1'b1;
          lk_data[l] = mem[rd_ptr + PW'(i)].data;
        end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: owns the single register-file write port.
//   clk, rst_n          : clock, async active-low reset
//   src (slave)         : ALU port A (always accepted) and multi-cycle port B
//                         (valid/ready, queued)
//   RdAddr/RdData/RegWrite : registered RF write, RF samples on negedge
//   rs_/rt_addr -> *_fwd_hit/_fwd_data : combinational bypass of pending writes
//   pending_cnt         : queued port-B entries, killed ones included
// A always wins the write slot; queued B results are older than any A result,
// so an A write kills queued B entries to the same register (WAW).
module rf_wb_arbiter #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = rf_pkg::ADDR_W,
  parameter int DATA_W = rf_pkg::DATA_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  rf_wb_arbiter_if.slave         src,
  output logic [ADDR_W-1:0]      RdAddr,
  output logic [DATA_W-1:0]      RdData,
  output logic                   RegWrite,
  input  logic [ADDR_W-1:0]      rs_addr,
  input  logic [ADDR_W-1:0]      rt_addr,
  output logic                   rs_fwd_hit,
  output logic [DATA_W-1:0]      rs_fwd_data,
  output logic                   rt_fwd_hit,
  output logic [DATA_W-1:0]      rt_fwd_data,
  output logic [$clog2(DEPTH):0] pending_cnt
);
  import rf_pkg::*;

  localparam int             NLK  = 2;
  localparam int             CW   = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0]  FULL = CW'(DEPTH);

  logic                       a_act, push, pop, empty;
  wb_entry_t                  head, push_ent;
  logic [CW-1:0]              cnt;
  logic [NLK-1:0][ADDR_W-1:0] lk_addr;
  logic [NLK-1:0]             q_hit, fwd_hit;
  logic [NLK-1:0][DATA_W-1:0] q_data, fwd_data;

  assign a_act       = src.a_valid && !is_zero_reg(src.a_addr);
  assign empty       = (cnt == '0);
  assign src.b_ready = (cnt != FULL);
  // r0 handshakes complete but leave nothing behind
  assign push        = src.b_valid && src.b_ready && !is_zero_reg(src.b_addr);
  assign pop         = !a_act && !empty;
  assign push_ent    = '{killed: 1'b0, addr: src.b_addr, data: src.b_data};
  assign lk_addr     = {rt_addr, rs_addr};
  assign pending_cnt = cnt;

  wb_queue #(.DEPTH(DEPTH), .NLK(NLK)) u_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_ent  (push_ent),
    .pop       (pop),
    .kill      (a_act),
    .kill_addr (src.a_addr),
    .head      (head),
    .cnt       (cnt),
    .lk_addr   (lk_addr),
    .lk_hit    (q_hit),
    .lk_data   (q_data)
  );

  // A killed head still consumes the slot, issued as a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      RegWrite <= 1'b0;
      RdAddr   <= '0;
      RdData   <= '0;
    end else if (a_act) begin
      RegWrite <= 1'b1;
      RdAddr   <= src.a_addr;
      RdData   <= src.a_data;
    end else if (!empty) begin
      RegWrite <= !head.killed;
      RdAddr   <= head.addr;
      RdData   <= head.data;
    end else begin
      RegWrite <= 1'b0;
    end
  end

  // Queue holds the youngest pending values; the output stage covers the
  // half cycle before its negedge RF write lands.
  always_comb begin
    fwd_hit  = '0;
    fwd_data = '0;
    for (int l = 0; l < NLK; l++)
      if (!is_zero_reg(lk_addr[l])) begin
        if (q_hit[l]) begin
          fwd_hit[l]  = 1'b1;
          fwd_data[l] = q_data[l];
        end else if (RegWrite && RdAddr == lk_addr[l]) begin
          fwd_hit[l]  = 1'b1;
          fwd_data[l] = RdData;
        end
      end
  end

  assign rs_fwd_hit  = fwd_hit[0];
  assign rs_fwd_data = fwd_data[0];
  assign rt_fwd_hit  = fwd_hit[1];
  assign rt_fwd_data = fwd_data[1];

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed scenarios with literal expectations plus
// randomized traffic, all checked against a queue-based reference model.
module tb_rf_wb_arbiter;
  localparam int DEPTH = 4;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic [4:0]             RdAddr, rs_addr, rt_addr;
  logic [31:0]            RdData, rs_fwd_data, rt_fwd_data;
  logic                   RegWrite, rs_fwd_hit, rt_fwd_hit;
  logic [$clog2(DEPTH):0] pending_cnt;

  rf_wb_arbiter_if bus ();

  rf_wb_arbiter #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .src         (bus),
    .RdAddr      (RdAddr),
    .RdData      (RdData),
    .RegWrite    (RegWrite),
    .rs_addr     (rs_addr),
    .rt_addr     (rt_addr),
    .rs_fwd_hit  (rs_fwd_hit),
    .rs_fwd_data (rs_fwd_data),
    .rt_fwd_hit  (rt_fwd_hit),
    .rt_fwd_data (rt_fwd_data),
    .pending_cnt (pending_cnt)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct {
    bit          k;
    logic [4:0]  addr;
    logic [31:0] data;
  } ment_t;

  ment_t       mq[$];
  logic        m_we;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  logic [31:0] dut_rf [32];
  int          checks = 0;
  int          errors = 0;
  bit          cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_we   = 1'b0;
    m_addr = '0;
    m_data = '0;
  endtask

  // One write-port cycle, from the rules: A wins and kills older same-reg
  // entries; otherwise oldest entry leaves (silently if killed).
  task automatic model_step();
    bit    a_act, full;
    ment_t e;
    if (!rst_n) begin
      model_reset();
      return;
    end
    a_act = bus.a_valid && bus.a_addr != 0;
    full  = (mq.size() == DEPTH);
    if (a_act)
      foreach (mq[i]) if (mq[i].addr == bus.a_addr) mq[i].k = 1'b1;
    if (a_act) begin
      m_we = 1'b1; m_addr = bus.a_addr; m_data = bus.a_data;
    end else if (mq.size() > 0) begin
      e = mq.pop_front();
      m_we = !e.k; m_addr = e.addr; m_data = e.data;
    end else begin
      m_we = 1'b0;
    end
    if (bus.b_valid && !full && bus.b_addr != 0)
      mq.push_back('{k: a_act && bus.b_addr == bus.a_addr, addr: bus.b_addr, data: bus.b_data});
  endtask

  function automatic void exp_fwd(input logic [4:0] a, output logic h, output logic [31:0] d);
    h = 1'b0;
    d = '0;
    if (a == 0) return;
    for (int i = mq.size() - 1; i >= 0; i--)
      if (!mq[i].k && mq[i].addr == a) begin
        h = 1'b1; d = mq[i].data;
        return;
      end
    if (m_we && m_addr == a) begin
      h = 1'b1; d = m_data;
    end
  endfunction

  // Single compare process; also mirrors the RF write the DUT requests.
  always @(negedge clk) begin
    logic        h;
    logic [31:0] d;
    if (cmp_en) begin
      chk("RegWrite", 32'(RegWrite), 32'(m_we));
      chk("RdAddr", 32'(RdAddr), 32'(m_addr));
      chk("RdData", RdData, m_data);
      chk("b_ready", 32'(bus.b_ready), 32'(mq.size() != DEPTH));
      chk("pending_cnt", 32'(pending_cnt), 32'(mq.size()));
      exp_fwd(rs_addr, h, d);
      chk("rs_fwd_hit", 32'(rs_fwd_hit), 32'(h));
      chk("rs_fwd_data", rs_fwd_data, d);
      exp_fwd(rt_addr, h, d);
      chk("rt_fwd_hit", 32'(rt_fwd_hit), 32'(h));
      chk("rt_fwd_data", rt_fwd_data, d);
      if (rst_n && RegWrite) dut_rf[RdAddr] = RdData;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    bus.a_valid = 1'b0; bus.a_addr = '0; bus.a_data = '0;
    bus.b_valid = 1'b0; bus.b_addr = '0; bus.b_data = '0;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  initial begin
    bit acc;
    int wcount;
    idle();
    rs_addr = 5'd5;
    rt_addr = 5'd0;
    model_reset();
    foreach (dut_rf[i]) dut_rf[i] = '0;
    cmp_en = 1'b1;

    // reset state
    #12;
    chk("rst RegWrite", 32'(RegWrite), 32'd0);
    chk("rst RdAddr", 32'(RdAddr), 32'd0);
    chk("rst RdData", RdData, 32'd0);
    chk("rst pending", 32'(pending_cnt), 32'd0);
    chk("rst b_ready", 32'(bus.b_ready), 32'd1);
    chk("rst rs_hit", 32'(rs_fwd_hit), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rs_addr = 5'd0;

    // 1: A only
    idle(); cyc();
    bus.a_valid = 1'b1; bus.a_addr = 5'd5; bus.a_data = 32'h11;
    cyc(); idle();
    at_neg();
    chk("t1 we", 32'(RegWrite), 32'd1);
    chk("t1 addr", 32'(RdAddr), 32'd5);
    chk("t1 data", RdData, 32'h11);
    cyc(); at_neg();
    chk("t1 we off", 32'(RegWrite), 32'd0);
    chk("t1 rf5", dut_rf[5], 32'h11);

    // 2: backpressure under continuous A, then drain
    bus.a_valid = 1'b1; bus.a_addr = 5'd20; bus.a_data = 32'h77;
    for (int k = 0; k < 4; k++) begin
      bus.b_valid = 1'b1; bus.b_addr = 5'(8 + k); bus.b_data = 32'(k + 1);
      cyc();
    end
    bus.b_addr = 5'd12; bus.b_data = 32'h5;
    at_neg();
    chk("t2 b_ready full", 32'(bus.b_ready), 32'd0);
    chk("t2 pending full", 32'(pending_cnt), 32'd4);
    cyc(); at_neg();
    chk("t2 pending held", 32'(pending_cnt), 32'd4);
    bus.a_valid = 1'b0;
    for (int j = 0; j < 5; j++) begin
      acc = bus.b_valid && bus.b_ready;
      cyc();
      if (acc) bus.b_valid = 1'b0;
      at_neg();
      chk("t2 drain we", 32'(RegWrite), 32'd1);
      chk("t2 drain addr", 32'(RdAddr), 32'(8 + j));
      chk("t2 drain data", RdData, 32'(j + 1));
    end

    // 3: WAW kill
    idle(); cyc();
    bus.b_valid = 1'b1; bus.b_addr = 5'd7; bus.b_data = 32'hAA;
    cyc();
    bus.b_valid = 1'b0; bus.a_valid = 1'b1; bus.a_addr = 5'd7; bus.a_data = 32'hBB;
    cyc(); idle();
    at_neg();
    chk("t3 we", 32'(RegWrite), 32'd1);
    chk("t3 addr", 32'(RdAddr), 32'd7);
    chk("t3 data", RdData, 32'hBB);
    chk("t3 pending", 32'(pending_cnt), 32'd1);
    cyc(); at_neg();
    chk("t3 bubble", 32'(RegWrite), 32'd0);
    chk("t3 pending0", 32'(pending_cnt), 32'd0);
    cyc(); at_neg();
    chk("t3 rf7", dut_rf[7], 32'hBB);

    // 4: bypass youngest match
    bus.a_valid = 1'b1; bus.a_addr = 5'd9; bus.a_data = 32'h99;
    bus.b_valid = 1'b1; bus.b_addr = 5'd3; bus.b_data = 32'h1;
    cyc();
    bus.b_data = 32'h2;
    cyc();
    bus.b_valid = 1'b0; rs_addr = 5'd3; rt_addr = 5'd4;
    at_neg();
    chk("t4 rs hit", 32'(rs_fwd_hit), 32'd1);
    chk("t4 rs data", rs_fwd_data, 32'h2);
    chk("t4 rt hit", 32'(rt_fwd_hit), 32'd0);
    chk("t4 rt data", rt_fwd_data, 32'd0);
    idle(); rs_addr = 5'd0; rt_addr = 5'd0;
    repeat (4) cyc();

    // 5: zero register on both ports
    bus.a_valid = 1'b1; bus.a_addr = 5'd0; bus.a_data = 32'h55;
    bus.b_valid = 1'b1; bus.b_addr = 5'd0; bus.b_data = 32'h66;
    #1;
    chk("t5 b_ready", 32'(bus.b_ready), 32'd1);
    cyc(); idle();
    at_neg();
    chk("t5 we", 32'(RegWrite), 32'd0);
    chk("t5 pending", 32'(pending_cnt), 32'd0);
    chk("t5 rs0 hit", 32'(rs_fwd_hit), 32'd0);

    // 6: reset mid-drain
    bus.a_valid = 1'b1; bus.a_addr = 5'd20; bus.a_data = 32'h20;
    for (int k = 0; k < 3; k++) begin
      bus.b_valid = 1'b1; bus.b_addr = 5'(13 + k); bus.b_data = 32'(32'h100 + k);
      cyc();
    end
    idle();
    cyc();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("t6 we", 32'(RegWrite), 32'd0);
    chk("t6 pending", 32'(pending_cnt), 32'd0);
    chk("t6 b_ready", 32'(bus.b_ready), 32'd1);
    cyc();
    @(negedge clk);
    rst_n = 1'b1;
    wcount = 0;
    repeat (6) begin
      cyc(); at_neg();
      if (RegWrite) wcount++;
    end
    chk("t6 stale writes", 32'(wcount), 32'd0);

    // randomized traffic: light then heavy A load
    for (int ph = 0; ph < 2; ph++)
      repeat (400) begin
        bus.a_valid = ($urandom_range(0, 99) < (ph == 0 ? 40 : 85));
        bus.a_addr  = 5'($urandom_range(0, 7));
        bus.a_data  = $urandom;
        bus.b_valid = ($urandom_range(0, 99) < 60);
        bus.b_addr  = 5'($urandom_range(0, 7));
        bus.b_data  = $urandom;
        rs_addr     = 5'($urandom_range(0, 7));
        rt_addr     = 5'($urandom_range(0, 7));
        cyc();
      end
    idle();
    repeat (8) cyc();
    at_neg();
    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
